// File: rtl/y_fetch_unit_if.sv
// y_fetch_unit_if: instruction-memory and decode-side signals of the fetch unit.
interface y_fetch_unit_if #(parameter int XLEN = 32);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic [31:0]     ins;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] PCp4;
    logic            ins_valid;
    logic            ins_ready;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            INT;
    logic [XLEN-1:0] entryPoint;

    modport master (
        output imem_req, imem_addr, ins, PC, PCp4, ins_valid,
        input  imem_gnt, imem_rvalid, imem_rdata, ins_ready, redirect, redirect_pc, INT, entryPoint
    );
    modport slave (
        input  imem_req, imem_addr, ins, PC, PCp4, ins_valid,
        output imem_gnt, imem_rvalid, imem_rdata, ins_ready, redirect, redirect_pc, INT, entryPoint
    );
endinterface

// File: rtl/y_fetch_unit.sv
// y_fetch_unit: fetch PC, one-outstanding imem request FSM and DEPTH-entry prefetch queue.
module y_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              STEP     = 4
) (
    input logic               clk,
    input logic               rst,
    y_fetch_unit_if.master    bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] ALIGN = ~XLEN'(3);

    state_e          state_q, state_d;
    logic [XLEN-1:0] fpc_q, fpc_d, req_pc_q, req_pc_d, tgt, head_pc;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic            discard_q, discard_d, flush, push, pop, valid;
    logic [31:0]     ins_mem [DEPTH];
    logic [XLEN-1:0] pc_mem  [DEPTH];

    always_comb begin
        flush     = bus.INT | bus.redirect;
        tgt       = (bus.INT ? bus.entryPoint : bus.redirect_pc) & ALIGN;
        valid     = (count_q != '0) && !flush;
        pop       = valid && bus.ins_ready;
        push      = (state_q == WAIT) && bus.imem_rvalid && !discard_q && !flush;
        state_d   = state_q;
        req_pc_d  = req_pc_q;
        if (state_q == IDLE && (flush || count_q < CW'(DEPTH))) begin
            state_d  = REQ;
            req_pc_d = flush ? tgt : fpc_q;
        end else if (state_q == REQ && bus.imem_gnt) begin
            state_d = WAIT;
        end else if (state_q == WAIT && bus.imem_rvalid) begin
            state_d = IDLE;
        end
        // once discarding, fpc already holds the redirect target and must not advance
        fpc_d     = flush ? tgt
                  : (state_q == REQ && bus.imem_gnt && !discard_q) ? fpc_q + XLEN'(STEP) : fpc_q;
        discard_d = (state_q == WAIT && bus.imem_rvalid) ? 1'b0
                  : (flush && state_q != IDLE) ? 1'b1 : discard_q;
        count_d   = flush ? '0 : count_q + CW'(push) - CW'(pop);
        rd_d      = flush ? '0 : pop ? rd_q + AW'(1) : rd_q;
        wr_d      = flush ? '0 : push ? wr_q + AW'(1) : wr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            fpc_q     <= RESET_PC & ALIGN;
            req_pc_q  <= RESET_PC & ALIGN;
            discard_q <= 1'b0;
            count_q   <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
        end else begin
            state_q   <= state_d;
            fpc_q     <= fpc_d;
            req_pc_q  <= req_pc_d;
            discard_q <= discard_d;
            count_q   <= count_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ins_mem[wr_q] <= bus.imem_rdata;
            pc_mem[wr_q]  <= req_pc_q;
        end
    end

    assign head_pc       = (count_q != '0) ? pc_mem[rd_q] : '0;
    assign bus.imem_req  = (state_q == REQ);
    assign bus.imem_addr = req_pc_q;
    assign bus.ins       = (count_q != '0) ? ins_mem[rd_q] : '0;
    assign bus.PC        = head_pc;
    assign bus.PCp4      = head_pc + XLEN'(STEP);
    assign bus.ins_valid = valid;
endmodule

// File: tb/tb_y_fetch_unit.sv
// tb_y_fetch_unit: random imem latency/redirect stimulus checked against a program-order stream model.
module tb_y_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    y_fetch_unit_if bus ();
    y_fetch_unit_if bus2 ();

    y_fetch_unit u_dut (.clk(clk), .rst(rst), .bus(bus));
    y_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (.clk(clk), .rst(rst), .bus(bus2));

    int n_vec = 0, n_err = 0, n_acc = 0, n_gnt = 0;
    int gnt_pct = 100, dly_min = 0, dly_max = 0;
    logic pend = 1'b0, req_hold = 1'b0, acc;
    int pdly = 0;
    logic [31:0] paddr = '0, hold_addr = '0, exp_pc = '0;
    logic last_req, last_gnt, last_valid;
    logic [31:0] last_addr, last_pc, last_pcp4;
    logic [31:0] w_pc [2], w_pcp4 [2];
    int w_n = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rdy, input logic rd, input logic [31:0] rpc,
                        input logic irq, input logic [31:0] ep);
        logic flush;
        logic [31:0] tgt;
        @(negedge clk);
        rst = 1'b0;
        bus.ins_ready = rdy; bus.redirect = rd; bus.redirect_pc = rpc;
        bus.INT = irq; bus.entryPoint = ep;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = $urandom;
        if (pend) begin
            if (pdly == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = word_of(paddr);
                pend = 1'b0;
            end else pdly--;
        end else if (bus.imem_req && $urandom_range(99, 0) < gnt_pct) begin
            bus.imem_gnt = 1'b1;
            pend = 1'b1;
            paddr = bus.imem_addr;
            pdly = $urandom_range(dly_max, dly_min);
            n_gnt++;
        end
        #1;
        flush = irq | rd;
        tgt = (irq ? ep : rpc) & ~32'h3;
        if (bus.imem_req) begin
            chk("addr_align", bus.imem_addr[1:0], 2'b00);
            if (req_hold) chk("addr_stable", bus.imem_addr, hold_addr);
        end
        req_hold  = bus.imem_req && !bus.imem_gnt;
        hold_addr = bus.imem_addr;
        if (flush) chk("valid_masked", bus.ins_valid, 1'b0);
        else if (!bus.ins_valid) begin
            chk("empty_ins", bus.ins, 32'h0);
            chk("empty_pc", bus.PC, 32'h0);
        end
        acc = bus.ins_valid && rdy;
        if (acc) begin
            chk("deliver_pc", bus.PC, exp_pc);
            chk("deliver_ins", bus.ins, word_of(exp_pc));
            chk("deliver_pcp4", bus.PCp4, exp_pc + 32'd4);
            exp_pc += 32'd4;
            n_acc++;
        end
        if (flush) exp_pc = tgt;
        last_req = bus.imem_req; last_gnt = bus.imem_gnt; last_addr = bus.imem_addr;
        last_valid = bus.ins_valid; last_pc = bus.PC; last_pcp4 = bus.PCp4;
    endtask

    task automatic idle_step(input logic rdy);
        step(rdy, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic do_reset(input logic keep_pend);
        @(negedge clk);
        rst = 1'b1;
        bus.ins_ready = 1'b0; bus.redirect = 1'b0; bus.INT = 1'b0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_valid", bus.ins_valid, 1'b0);
        chk("rst_req", bus.imem_req, 1'b0);
        exp_pc = 32'h0;
        req_hold = 1'b0;
        n_gnt = 0;
        if (!keep_pend) pend = 1'b0;
    endtask

    task automatic wait_accept(input string tag);
        logic ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            idle_step(1'b1);
            if (acc) begin ok = 1'b1; break; end
        end
        chk(tag, ok, 1'b1);
    endtask

    initial begin
        bus2.imem_gnt = 1'b0; bus2.imem_rvalid = 1'b0; bus2.imem_rdata = '0;
        bus2.ins_ready = 1'b1; bus2.redirect = 1'b0; bus2.redirect_pc = '0;
        bus2.INT = 1'b0; bus2.entryPoint = '0;
        forever begin
            logic p2 = 1'b0;
            logic [31:0] a2 = '0;
            @(negedge clk);
            bus2.imem_rvalid = p2;
            bus2.imem_rdata  = word_of(a2);
            p2 = bus2.imem_req;
            bus2.imem_gnt = bus2.imem_req;
            if (bus2.imem_req) a2 = bus2.imem_addr;
            #1;
            if (bus2.ins_valid && !rst && w_n < 2) begin
                w_pc[w_n] = bus2.PC;
                w_pcp4[w_n] = bus2.PCp4;
                w_n++;
            end
        end
    end

    initial begin
        logic found;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        bus.ins_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
        bus.INT = 1'b0; bus.entryPoint = '0;

        // best case: immediate gnt, one-cycle rvalid
        do_reset(1'b0);
        idle_step(1'b1); chk("c0_req", last_req, 1'b0);
        idle_step(1'b1); chk("c1_req", last_req, 1'b1); chk("c1_addr", last_addr, 32'h0);
        idle_step(1'b1); chk("c2_valid", last_valid, 1'b0);
        idle_step(1'b1); chk("c3_valid", last_valid, 1'b1);
        chk("c3_pc", last_pc, 32'h0); chk("c3_pcp4", last_pcp4, 32'h4);
        idle_step(1'b1); chk("c4_addr", last_addr, 32'h4); chk("c4_req", last_req, 1'b1);
        idle_step(1'b1); idle_step(1'b1);
        idle_step(1'b1); chk("c7_addr", last_addr, 32'h8); chk("c7_req", last_req, 1'b1);

        // decode stalled: queue fills to DEPTH then fetch stops
        do_reset(1'b0);
        for (int i = 0; i < 20; i++) idle_step(1'b0);
        chk("full_gnts", n_gnt, 2);
        chk("full_req", last_req, 1'b0);
        chk("full_valid", last_valid, 1'b1);
        wait_accept("full_drain0");
        wait_accept("full_drain1");
        wait_accept("full_resume");

        // redirect while waiting on the response for 0x8
        do_reset(1'b0);
        dly_min = 2; dly_max = 2;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            idle_step(1'b1);
            if (last_gnt && last_addr == 32'h8) begin found = 1'b1; break; end
        end
        chk("redir_gnt8", found, 1'b1);
        step(1'b1, 1'b1, 32'h0000_0101, 1'b0, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            idle_step(1'b1);
            if (last_req) begin found = 1'b1; break; end
        end
        chk("redir_req", found, 1'b1);
        chk("redir_addr", last_addr, 32'h100);
        wait_accept("redir_deliver");

        // INT beats redirect, issued from IDLE
        do_reset(1'b0);
        dly_min = 0; dly_max = 0;
        step(1'b1, 1'b1, 32'h200, 1'b1, 32'h83);
        idle_step(1'b1);
        chk("int_req", last_req, 1'b1);
        chk("int_addr", last_addr, 32'h80);
        wait_accept("int_deliver");

        // reset with one entry queued and a response still outstanding
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) idle_step(1'b0);
        dly_min = 10; dly_max = 10;
        for (int i = 0; i < 3; i++) idle_step(1'b0);
        chk("prerst_valid", last_valid, 1'b1);
        chk("prerst_pc", last_pc, 32'h0);
        do_reset(1'b1);
        pdly = 0;
        dly_min = 0; dly_max = 0;
        idle_step(1'b1);
        chk("late_rvalid_valid", last_valid, 1'b0);
        wait_accept("rst_restart");

        // random traffic
        do_reset(1'b0);
        n_acc = 0;
        gnt_pct = 60; dly_min = 0; dly_max = 3;
        for (int i = 0; i < 3000; i++) begin
            int r = $urandom_range(99, 0);
            step($urandom_range(99, 0) < 70, r < 3, $urandom & 32'h0000_0FFF,
                 r == 99, $urandom & 32'h0000_FFFF);
        end
        chk("rand_progress", n_acc >= 100, 1'b1);

        chk("wrap_count", w_n, 2);
        chk("wrap_pc0", w_pc[0], 32'hFFFF_FFFC);
        chk("wrap_pcp4", w_pcp4[0], 32'h0);
        chk("wrap_pc1", w_pc[1], 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
